adder_seq_ctrl: RTL and testbench
=================================

# adder_seq_ctrl

Multi-cycle sequencer that performs WIDTH-bit add/subtract by time-multiplexing one external SLICE-bit carry-lookahead adder slice. It latches operands via a valid/ready handshake and feeds the slice one chunk per cycle, LSB chunk first. The carry is held in a register between chunks. It returns the full result, carry-out and signed overflow via a second valid/ready handshake. It sits between the operand-issue logic and the shared lookahead adder.

## Interface
- WIDTH, 64, operand/result width; must be an integer multiple of SLICE
- SLICE, 16, width of the external adder slice; NSLICE = WIDTH/SLICE ≥ 1
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- in_valid_i  in  1  operand request valid
- in_ready_o  out  1  block can accept a request
- a_i  in  WIDTH  operand A
- b_i  in  WIDTH  operand B
- cin_i  in  1  carry-in (add only)
- sub_i  in  1  1 = A − B, 0 = A + B + cin_i
- slice_a_o  out  SLICE  current A chunk to adder slice
- slice_b_o  out  SLICE  current effective-B chunk to adder slice
- slice_cin_o  out  1  carry into adder slice
- slice_sum_i  in  SLICE  slice sum (combinational from slice_*_o)
- slice_cout_i  in  1  slice carry-out (combinational)
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- sum_o  out  WIDTH  result
- cout_o  out  1  final carry-out
- ovf_o  out  1  signed (two's-complement) overflow

## Operation
- States: IDLE, RUN, DONE. in_ready_o = (state==IDLE). out_valid_o = (state==DONE).
- IDLE, in_valid_i=1: latch a_q=a_i and b_q = sub_i ? ~b_i : b_i. Set carry_q = sub_i ? 1 : cin_i. Clear idx to 0 → RUN.
- RUN: slice_a_o = a_q[idx*SLICE +: SLICE]; slice_b_o = b_q chunk idx; slice_cin_o = carry_q.
  - Each cycle: write slice_sum_i into result chunk idx, carry_q ← slice_cout_i.
  - idx==NSLICE−1 → DONE; otherwise idx ← idx+1.
- DONE: sum_o, cout_o (= final carry_q) and ovf_o are held stable. ovf_o = (a_q[MSB]==b_q[MSB]) && (sum[MSB]!=a_q[MSB]). On out_ready_i=1 → IDLE.
- Outside RUN: slice_a_o, slice_b_o, slice_cin_o = 0.
- sum_o, cout_o, ovf_o keep their last value in IDLE/RUN until the next result is written. They are only meaningful when out_valid_o=1.
- in_valid_i in RUN/DONE is ignored (not accepted). out_ready_i outside DONE is ignored.
- Sub: cout_o=1 means no borrow (A ≥ B unsigned).
- NSLICE=1: RUN lasts exactly one cycle.

## Timing
- Reset (rst_n_i low, asynchronous): state=IDLE, idx=0, carry_q=0, a_q=b_q=0. Outputs: in_ready_o=1, out_valid_o=0, sum_o=0, cout_o=0, ovf_o=0, slice_*_o=0.
- Reset asserted mid-RUN or DONE aborts the operation immediately. The result is discarded and no out_valid_o is produced.
- Accept at edge E0 (in_valid_i & in_ready_o). RUN occupies cycles 1..NSLICE after E0. out_valid_o rises in cycle NSLICE+1.
- Latency from accept to out_valid_o is NSLICE+1 cycles (5 for default).
- Return to IDLE occurs on the edge where out_valid_o & out_ready_i. in_ready_o is high the following cycle.
- Minimum request spacing: NSLICE+2 cycles.
- slice_sum_i and slice_cout_i are sampled at the end of each RUN cycle. The slice path must close in one clock.

## Test plan
- Add carry ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0, sub=0 → sum_o=0, cout_o=1, ovf_o=0. out_valid_o 5 cycles after accept; slice_cin_o=1 in RUN cycles 2–4.
- Subtract: a=5, b=7, sub=1 → sum_o=0xFFFF_FFFF_FFFF_FFFE, cout_o=0, ovf_o=0. slice_b_o chunk0=0xFFF8, slice_cin_o=1 in RUN cycle 1.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 → sum_o=0x8000_0000_0000_0000, ovf_o=1, cout_o=0. Also a=0x0000_0000_0000_FFFF, b=1, cin=1 → sum_o=0x0000_0000_0001_0001.
- Backpressure: hold out_ready_i=0 for 10 cycles in DONE. out_valid_o, sum_o, cout_o, ovf_o stay stable and in_ready_o=0. A pulsed in_valid_i is not accepted. out_ready_i=1 → IDLE next cycle.
- Reset mid-operation: drop rst_n_i in RUN cycle 2. Immediately out_valid_o=0, in_ready_o=1, sum_o=0, slice_*_o=0. After release, a new request completes normally with the correct result.
- Back-to-back: issue two requests with in_valid_i held high throughout. The second is accepted exactly on the first IDLE cycle after the first result handshake, and both results are correct.

Source files
------------

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: performs WIDTH-bit add/subtract by feeding an external
// SLICE-bit adder slice one chunk per cycle, LSB chunk first. The carry is
// held between chunks, and a valid/ready handshake is used on each side.
module adder_seq_ctrl #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic [SLICE-1:0] slice_a_o,
  output logic [SLICE-1:0] slice_b_o,
  output logic             slice_cin_o,
  input  logic [SLICE-1:0] slice_sum_i,
  input  logic             slice_cout_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  // Partial result with the current slice sum merged into chunk idx.
  logic [WIDTH-1:0] res_d;
  logic             ovf_d;
  logic             last_chunk;

  logic [SLICE-1:0] a_chunk [NSLICE];
  logic [SLICE-1:0] b_chunk [NSLICE];

  // Split the latched operands into chunks and build the merged result.
  for (genvar gi = 0; gi < NSLICE; gi++) begin : g_chunk
    assign a_chunk[gi] = a_q[gi*SLICE +: SLICE];
    assign b_chunk[gi] = b_q[gi*SLICE +: SLICE];
    assign res_d[gi*SLICE +: SLICE] =
        (idx_q == IDX_W'(gi)) ? slice_sum_i : res_q[gi*SLICE +: SLICE];
  end

  assign last_chunk = (idx_q == IDX_W'(NSLICE - 1));

  // Signed overflow: operands (B already inverted for subtract) agree in
  // sign, but the final sum's sign differs from them.
  assign ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                 (res_d[WIDTH-1] != a_q[WIDTH-1]);

  // Drive the adder slice only while running; quiet zeros otherwise.
  always_comb begin
    slice_a_o   = '0;
    slice_b_o   = '0;
    slice_cin_o = 1'b0;
    if (state_q == RUN) begin
      slice_a_o   = a_chunk[idx_q];
      slice_b_o   = b_chunk[idx_q];
      slice_cin_o = carry_q;
    end
  end

  // Sequencer FSM: accept operands, step through chunks, hold the result.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            a_q        <= a_i;
            // Subtract is A + ~B + 1.
            b_q        <= sub_i ? ~b_i : b_i;
            carry_q    <= sub_i ? 1'b1 : cin_i;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          res_q   <= res_d;
          carry_q <= slice_cout_i;
          if (last_chunk) begin
            // Publish the whole result at once so sum_o never shows a
            // partially built value.
            sum_q       <= res_d;
            cout_q      <= slice_cout_i;
            ovf_q       <= ovf_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Testbench for adder_seq_ctrl: models the external adder slice, issues
// directed requests and checks results through a scoreboard queue.
module tb_adder_seq_ctrl;

  localparam int WIDTH = 64;
  localparam int SLICE = 16;
  localparam int NS    = WIDTH / SLICE;

  logic             clk_i = 1'b0;
  logic             rst_n_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;
  logic             sub_i;
  logic [SLICE-1:0] slice_a_o;
  logic [SLICE-1:0] slice_b_o;
  logic             slice_cin_o;
  logic [SLICE-1:0] slice_sum_i;
  logic             slice_cout_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;
  logic             ovf_o;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  adder_seq_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .a_i          (a_i),
    .b_i          (b_i),
    .cin_i        (cin_i),
    .sub_i        (sub_i),
    .slice_a_o    (slice_a_o),
    .slice_b_o    (slice_b_o),
    .slice_cin_o  (slice_cin_o),
    .slice_sum_i  (slice_sum_i),
    .slice_cout_i (slice_cout_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .sum_o        (sum_o),
    .cout_o       (cout_o),
    .ovf_o        (ovf_o)
  );

  // External combinational adder slice.
  assign {slice_cout_i, slice_sum_i} =
      17'(slice_a_o) + 17'(slice_b_o) + 17'(slice_cin_o);

  always #5 clk_i = ~clk_i;

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h @%0t", name, act, req, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b @%0t", name, act, req, $time);
    end
  endtask

  // Monitor: every result handshake pops one expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_n_i && out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got sum 0x%016h with no request outstanding", sum_o);
        end else begin
          e = exp_q.pop_front();
          chk64("sb_sum", sum_o, e.s);
          chk1("sb_cout", cout_o, e.c);
          chk1("sb_ovf", ovf_o, e.o);
          $display("result sum=0x%016h cout=%b ovf=%b", sum_o, cout_o, ovf_o);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One complete request. cin_mask bit k = expected slice_cin_o in RUN
  // cycle k+1. hold>0 applies that many cycles of backpressure in DONE.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic sub,
                        input logic [63:0] es, input logic ec, input logic eo,
                        input logic [3:0] cin_mask,
                        input logic chk_b0, input logic [15:0] b0,
                        input int hold);
    int w;
    logic [3:0] m;
    exp_t e;
    @(posedge clk_i);
    #1;
    out_ready_i = (hold == 0);
    @(negedge clk_i);
    w = 0;
    while (!in_ready_o && w < 20) begin
      @(negedge clk_i);
      w++;
    end
    chk1("in_ready_wait", in_ready_o, 1'b1);
    a_i = a; b_i = b; cin_i = cin; sub_i = sub; in_valid_i = 1'b1;
    @(posedge clk_i);
    e.s = es; e.c = ec; e.o = eo;
    exp_q.push_back(e);
    $display("issue a=0x%016h b=0x%016h cin=%b sub=%b", a, b, cin, sub);
    #1;
    in_valid_i = 1'b0;
    m = cin_mask;
    for (int c = 1; c <= NS; c++) begin
      @(negedge clk_i);
      chk1("run_valid_low", out_valid_o, 1'b0);
      chk1("run_ready_low", in_ready_o, 1'b0);
      chk1("slice_cin", slice_cin_o, m[0]);
      m = m >> 1;
      if (chk_b0 && c == 1) chk64("slice_b_chunk0", 64'(slice_b_o), 64'(b0));
    end
    @(negedge clk_i);
    chk1("latency_valid", out_valid_o, 1'b1);
    chk64("idle_slice_a", 64'(slice_a_o), 64'd0);
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        @(posedge clk_i);
        #1;
        if (k == 3) begin
          a_i = 64'h1111; b_i = 64'h2222; cin_i = 1'b0; sub_i = 1'b0;
          in_valid_i = 1'b1;
        end
        if (k == 4) in_valid_i = 1'b0;
        @(negedge clk_i);
        chk1("bp_valid", out_valid_o, 1'b1);
        chk1("bp_ready", in_ready_o, 1'b0);
        chk64("bp_sum", sum_o, es);
        chk1("bp_cout", cout_o, ec);
        chk1("bp_ovf", ovf_o, eo);
      end
      @(posedge clk_i);
      #1;
      out_ready_i = 1'b1;
      @(negedge clk_i);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    chk1("post_hs_ready", in_ready_o, 1'b1);
    chk1("post_hs_valid", out_valid_o, 1'b0);
    if (hold > 0) begin
      // The pulse during DONE must not have started a new operation.
      for (int k = 0; k < NS + 2; k++) begin
        @(negedge clk_i);
        chk1("bp_no_accept_ready", in_ready_o, 1'b1);
        chk1("bp_no_accept_valid", out_valid_o, 1'b0);
      end
    end
  endtask

  initial begin
    exp_t e;
    rst_n_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
    a_i = '0; b_i = '0; cin_i = 1'b0; sub_i = 1'b0;
    #2 rst_n_i = 1'b0;
    #1;
    chk1("rst_in_ready", in_ready_o, 1'b1);
    chk1("rst_out_valid", out_valid_o, 1'b0);
    chk64("rst_sum", sum_o, 64'd0);
    chk1("rst_cout", cout_o, 1'b0);
    chk1("rst_ovf", ovf_o, 1'b0);
    chk64("rst_slice_a", 64'(slice_a_o), 64'd0);
    chk64("rst_slice_b", 64'(slice_b_o), 64'd0);
    chk1("rst_slice_cin", slice_cin_o, 1'b0);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;

    // Carry ripple across all chunks.
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
           64'd0, 1'b1, 1'b0, 4'b1110, 1'b0, 16'h0, 0);
    // Subtract with borrow.
    run_op(64'd5, 64'd7, 1'b0, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 4'b0001, 1'b1, 16'hFFF8, 0);
    // Signed overflow, with backpressure in DONE.
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1, 4'b1110, 1'b0, 16'h0, 10);
    // Carry-in used on add.
    run_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b1, 1'b0,
           64'h0000_0000_0001_0001, 1'b0, 1'b0, 4'b0011, 1'b1, 16'h0001, 0);

    // Back-to-back with in_valid_i held high throughout.
    @(negedge clk_i);
    chk1("b2b_ready0", in_ready_o, 1'b1);
    a_i = 64'h1234_5678_9ABC_DEF0; b_i = 64'h0FED_CBA9_8765_4321;
    cin_i = 1'b0; sub_i = 1'b0; in_valid_i = 1'b1; out_ready_i = 1'b1;
    @(posedge clk_i);
    e.s = 64'h2222_2222_2222_2211; e.c = 1'b0; e.o = 1'b0;
    exp_q.push_back(e);
    $display("issue b2b first a=0x%016h b=0x%016h", a_i, b_i);
    #1;
    a_i = 64'h8000_0000_0000_0000; b_i = 64'd1; cin_i = 1'b0; sub_i = 1'b1;
    for (int c = 1; c <= 2 * (NS + 1) + 1; c++) begin
      @(negedge clk_i);
      chk1("b2b_in_ready", in_ready_o, (c == NS + 2));
      chk1("b2b_out_valid", out_valid_o, (c == NS + 1) || (c == 2 * (NS + 1) + 1));
      @(posedge clk_i);
      if (c == NS + 2) begin
        e.s = 64'h7FFF_FFFF_FFFF_FFFF; e.c = 1'b1; e.o = 1'b1;
        exp_q.push_back(e);
        $display("issue b2b second a=0x%016h b=0x%016h sub=1", a_i, b_i);
        #1;
        in_valid_i = 1'b0;
      end
    end
    @(negedge clk_i);
    chk1("b2b_end_ready", in_ready_o, 1'b1);

    // Reset in RUN cycle 2 aborts the operation.
    a_i = 64'd3; b_i = 64'd4; cin_i = 1'b0; sub_i = 1'b0; in_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    @(posedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk1("arst_out_valid", out_valid_o, 1'b0);
    chk1("arst_in_ready", in_ready_o, 1'b1);
    chk64("arst_sum", sum_o, 64'd0);
    chk64("arst_slice_a", 64'(slice_a_o), 64'd0);
    chk64("arst_slice_b", 64'(slice_b_o), 64'd0);
    chk1("arst_slice_cin", slice_cin_o, 1'b0);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int k = 0; k < NS + 3; k++) begin
      @(negedge clk_i);
      chk1("post_rst_valid", out_valid_o, 1'b0);
      chk1("post_rst_ready", in_ready_o, 1'b1);
    end
    run_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b1, 1'b0,
           64'h0000_0000_0001_0001, 1'b0, 1'b0, 4'b0011, 1'b0, 16'h0, 0);

    repeat (3) @(negedge clk_i);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
